// File: rtl/irq_vector_arbiter.sv
// irq_vector_arbiter: vectored interrupt arbiter with per-device iack handshake.
// Define IRQ_ARB_ROTATE_EN for round-robin priority; fixed priority (index 0 highest) otherwise.
module irq_vector_arbiter #(
  parameter int NREQ = 4,
  parameter logic [16*NREQ-1:0] VECTORS = {16'o000330, 16'o000320, 16'o000310, 16'o000300}
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [NREQ-1:0] irq_i,
  output logic [NREQ-1:0] iack_o,
  output logic            cpu_virq_o,
  input  logic            cpu_istb_i,
  output logic [15:0]     cpu_ivec_o,
  output logic            cpu_iack_o
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, ACK, GAP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, win, base;
  logic [NREQ-1:0] iack_q, iack_d, rot;
  logic [2*NREQ-1:0] dbl;
  logic [15:0] ivec_q, ivec_d;
  logic virq_q, virq_d, ciack_q, ciack_d;
`ifdef IRQ_ARB_ROTATE_EN
  logic [GW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = (state_q == ACK && !cpu_istb_i) ? GW'((int'(g_q) + 1) % NREQ) : ptr_q;
  always_ff @(posedge wb_clk_i) ptr_q <= !wb_rst_ni ? '0 : ptr_d;
  assign base = ptr_q;
`else
  assign base = '0;
`endif
  // Rotate requests so the scan starts at base; the lowest set bit of rot wins.
  always_comb begin
    dbl = {irq_i, irq_i} >> base;
    rot = dbl[NREQ-1:0];
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) win = GW'((int'(base) + i) % NREQ);
  end
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    virq_d  = virq_q;
    iack_d  = iack_q;
    ivec_d  = ivec_q;
    ciack_d = ciack_q;
    case (state_q)
      IDLE: if (|irq_i) begin
        g_d     = win;
        virq_d  = 1'b1;
        state_d = GRANT;
      end
      GRANT: if (!irq_i[g_q]) begin
        virq_d  = 1'b0;
        state_d = IDLE;
      end else if (cpu_istb_i) begin
        iack_d  = NREQ'(1) << g_q;
        ivec_d  = VECTORS[16*g_q +: 16];
        ciack_d = 1'b1;
        virq_d  = 1'b0;
        state_d = ACK;
      end
      ACK: if (!cpu_istb_i) begin
        iack_d  = '0;
        ivec_d  = '0;
        ciack_d = 1'b0;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      virq_q  <= 1'b0;
      iack_q  <= '0;
      ivec_q  <= '0;
      ciack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      virq_q  <= virq_d;
      iack_q  <= iack_d;
      ivec_q  <= ivec_d;
      ciack_q <= ciack_d;
    end
  end
  assign iack_o     = iack_q;
  assign cpu_virq_o = virq_q;
  assign cpu_ivec_o = ivec_q;
  assign cpu_iack_o = ciack_q;
endmodule

// File: tb/tb_irq_vector_arbiter.sv
// tb_irq_vector_arbiter: randomized transactions checked against a transaction-level model.
module tb_irq_vector_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, istb = 1'b0, virq, ciack;
  logic [N-1:0] irq = '0, iack;
  logic [15:0] ivec;
  int checks = 0, errors = 0, ptr = 0;
  always #5 clk = ~clk;
  irq_vector_arbiter dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .irq_i(irq), .iack_o(iack),
    .cpu_virq_o(virq), .cpu_istb_i(istb), .cpu_ivec_o(ivec), .cpu_iack_o(ciack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic v, input logic a, input logic [N-1:0] ia, input logic [15:0] vec);
    check({tag, ".virq"}, 32'(virq), 32'(v));
    check({tag, ".cpu_iack"}, 32'(ciack), 32'(a));
    check({tag, ".iack"}, 32'(iack), 32'(ia));
    check({tag, ".ivec"}, 32'(ivec), 32'(vec));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] vec_of(input int i);
    return 16'(16'o300 + 8 * i);
  endfunction
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction
  task automatic serve(input logic [N-1:0] r, input int wait_c, input int hold);
    int w;
    w = pick(r);
    irq = r;
    istb = 1'b0;
    tick;
    outs("req", 1'b1, 1'b0, '0, '0);
    repeat (wait_c) begin
      irq = irq | N'($urandom);
      tick;
      outs("wait", 1'b1, 1'b0, '0, '0);
    end
    istb = 1'b1;
    tick;
    outs("ack", 1'b0, 1'b1, N'(1) << w, vec_of(w));
    repeat (hold) begin
      irq = N'($urandom);
      tick;
      outs("hold", 1'b0, 1'b1, N'(1) << w, vec_of(w));
    end
    istb = 1'b0;
    irq = '0;
    tick;
    outs("rel", 1'b0, 1'b0, '0, '0);
    irq = N'($urandom);
    tick;
    outs("gap", 1'b0, 1'b0, '0, '0);
    irq = '0;
`ifdef IRQ_ARB_ROTATE_EN
    ptr = (w + 1) % N;
`endif
  endtask
  task automatic withdraw(input logic [N-1:0] r);
    irq = r;
    istb = 1'b0;
    tick;
    outs("wd_req", 1'b1, 1'b0, '0, '0);
    irq = '0;
    istb = 1'($urandom);
    tick;
    outs("wd", 1'b0, 1'b0, '0, '0);
    repeat (2) begin
      tick;
      outs("wd_idle", 1'b0, 1'b0, '0, '0);
    end
    istb = 1'b0;
  endtask
  task automatic stray;
    irq = '0;
    istb = 1'b1;
    repeat (4) begin
      tick;
      outs("stray", 1'b0, 1'b0, '0, '0);
    end
    istb = 1'b0;
  endtask
  task automatic reset_in_ack(input logic [N-1:0] r);
    irq = r;
    tick;
    outs("rs_req", 1'b1, 1'b0, '0, '0);
    istb = 1'b1;
    tick;
    outs("rs_ack", 1'b0, 1'b1, N'(1) << pick(r), vec_of(pick(r)));
    rst_n = 1'b0;
    tick;
    outs("rs_rst", 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    istb = 1'b0;
    irq = '0;
    ptr = 0;
    tick;
    outs("rs_idle", 1'b0, 1'b0, '0, '0);
  endtask
  initial begin
    repeat (2) tick;
    outs("reset", 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    tick;
    outs("idle", 1'b0, 1'b0, '0, '0);
    serve(4'b0001, 2, 0);
    serve(4'b0110, 0, 1);
    serve(4'b0100, 1, 0);
    withdraw(4'b0001);
    stray;
    reset_in_ack(4'b0001);
    repeat (4) serve(4'b0011, 0, 0);
    for (int t = 0; t < 80; t++) begin
      case ($urandom % 8)
        0: withdraw(N'($urandom_range(1, 15)));
        1: stray;
        2: reset_in_ack(N'($urandom_range(1, 15)));
        default: serve(N'($urandom_range(1, 15)), $urandom % 3, $urandom % 4);
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
